// File: rtl/cdc_sample_receiver.sv
// rtl/cdc_sample_receiver.sv - destination end of the 4-phase req/ack sample handshake
// Synchronizes tx_req, captures one sample per request, queues it in an FWFT FIFO for the DAC side.
module cdc_sample_receiver #(
   parameter int DATA_WIDTH  = 12,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tx_req,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic                       tx_ack,
   output logic [DATA_WIDTH-1:0]      sample_data,
   output logic                       sample_valid,
   input  logic                       sample_ready,
   output logic [DATA_WIDTH-1:0]      dac_code,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       underrun
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, ACK} state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   req_s;
   state_t                 state;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;
   logic                   push;
   logic                   pop;

   assign req_s        = sync[SYNC_STAGES-1];
   // Full decision looks at the registered count only, so a same-cycle pop never frees a slot early
   assign push         = (state == IDLE) && req_s && (count < FULL);
   assign sample_valid = (count != '0);
   assign pop          = sample_valid && sample_ready;
   assign sample_data  = mem[rd_ptr];
   assign fill_level   = count;

   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], tx_req};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         tx_ack <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (push) begin
                  tx_ack <= 1'b1;
                  state  <= ACK;
               end
            end
            ACK: begin
               if (!req_s) begin
                  tx_ack <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               tx_ack <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // data_in has been stable for SYNC_STAGES cycles by the time push is seen
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         dac_code <= '0;
         underrun <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            dac_code <= sample_data;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (sample_ready && !sample_valid) underrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cdc_sample_receiver.sv
// tb/tb_cdc_sample_receiver.sv - scoreboard bench for cdc_sample_receiver
// Directed handshake sequences; popped samples are compared against a queue of sent samples.
module tb_cdc_sample_receiver;

   localparam int DW = 12;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          tx_req;
   logic [DW-1:0] data_in;
   logic          tx_ack;
   logic [DW-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic [DW-1:0] dac_code;
   logic [2:0]    fill_level;
   logic          underrun;

   int checks = 0;
   int fails  = 0;
   logic [DW-1:0] sb [$];
   logic [DW-1:0] exp_dac = '0;

   cdc_sample_receiver #(.DATA_WIDTH(DW), .DEPTH(4), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .tx_req(tx_req), .data_in(data_in), .tx_ack(tx_ack),
      .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .dac_code(dac_code), .fill_level(fill_level), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until tx_ack reaches the wanted level (bounded)
   task automatic wait_ack(input logic level, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (tx_ack !== level && n < 50);
   endtask

   // Scoreboard side: a pop happens at the next edge when valid && ready at mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         exp_dac = '0;
      end else begin
         check("dac_code_held", dac_code, exp_dac);
         if (sample_valid && sample_ready) begin
            if (sb.size() == 0) begin
               check("pop_with_empty_scoreboard", 1, 0);
            end else begin
               exp_dac = sb.pop_front();
               check("pop_data", sample_data, exp_dac);
            end
         end
      end
   end

   initial begin : stim
      int n;
      rst = 1'b1; tx_req = 1'b0; data_in = '0; sample_ready = 1'b0;
      tick(); tick();
      check("rst_tx_ack", tx_ack, 0);
      check("rst_fill", fill_level, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_underrun", underrun, 0);
      check("rst_dac", dac_code, 0);
      rst = 1'b0;
      tick();

      // Single transfer
      data_in = 12'hABC; tx_req = 1'b1;
      wait_ack(1'b1, n);
      sb.push_back(12'hABC);
      check("single_ack_latency", n, S + 1);
      check("single_valid", sample_valid, 1);
      check("single_head", sample_data, 12'hABC);
      tx_req = 1'b0;
      wait_ack(1'b0, n);
      check("single_ack_fall_latency", n, S + 1);
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
      check("single_pop_dac", dac_code, 12'hABC);
      check("single_pop_fill", fill_level, 0);

      // Long request high phase: one capture only
      data_in = 12'h5A5; tx_req = 1'b1;
      wait_ack(1'b1, n);
      sb.push_back(12'h5A5);
      check("long_ack_latency", n, S + 1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_ack === 1'b1) n++;
      end
      check("long_ack_held", n, 20);
      check("long_fill_one", fill_level, 1);
      tx_req = 1'b0;
      wait_ack(1'b0, n);
      check("long_ack_fall", n, S + 1);
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
      check("long_drained", fill_level, 0);

      // Backpressure: fill, stall a fifth request, free one slot
      for (int i = 1; i <= 4; i++) begin
         data_in = DW'(i); tx_req = 1'b1;
         wait_ack(1'b1, n);
         sb.push_back(DW'(i));
         check("bp_ack_latency", n, S + 1);
         tx_req = 1'b0;
         wait_ack(1'b0, n);
      end
      check("bp_full", fill_level, 4);
      data_in = 12'h005; tx_req = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_ack === 1'b1) n++;
      end
      check("bp_no_ack_when_full", n, 0);
      check("bp_still_full", fill_level, 4);
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
      check("bp_fill_after_pop", fill_level, 3);
      check("bp_ack_not_yet", tx_ack, 0);
      tick();
      sb.push_back(12'h005);
      check("bp_ack_next_cycle", tx_ack, 1);
      check("bp_refilled", fill_level, 4);
      tx_req = 1'b0;
      wait_ack(1'b0, n);
      sample_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      sample_ready = 1'b0;
      check("bp_drained", fill_level, 0);

      // Simultaneous push/pop at fill 2, ten samples across pointer wrap
      for (int i = 0; i < 10; i++) begin
         data_in = DW'(12'h100 + i); tx_req = 1'b1;
         if (i < 2) begin
            wait_ack(1'b1, n);
         end else begin
            tick(); tick();
            sample_ready = 1'b1;
            tick();
            sample_ready = 1'b0;
            check("pp_ack", tx_ack, 1);
            check("pp_fill_steady", fill_level, 2);
         end
         sb.push_back(DW'(12'h100 + i));
         tx_req = 1'b0;
         wait_ack(1'b0, n);
      end
      sample_ready = 1'b1; tick(); tick(); sample_ready = 1'b0;
      check("pp_drained", fill_level, 0);
      check("pp_last_dac", dac_code, 12'h109);
      check("pp_no_underrun_yet", underrun, 0);

      // Underrun is sticky, dac_code holds
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
      check("ur_set", underrun, 1);
      check("ur_dac_held", dac_code, 12'h109);
      data_in = 12'h3C3; tx_req = 1'b1;
      wait_ack(1'b1, n);
      sb.push_back(12'h3C3);
      tx_req = 1'b0;
      wait_ack(1'b0, n);
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
      check("ur_pop_after", dac_code, 12'h3C3);
      check("ur_still_set", underrun, 1);

      // Reset while in ACK with tx_req high, then recapture
      data_in = 12'h777; tx_req = 1'b1;
      wait_ack(1'b1, n);
      check("mr_ack_before_reset", tx_ack, 1);
      rst = 1'b1; tick();
      sb.delete();
      check("mr_tx_ack", tx_ack, 0);
      check("mr_fill", fill_level, 0);
      check("mr_underrun", underrun, 0);
      check("mr_valid", sample_valid, 0);
      rst = 1'b0;
      wait_ack(1'b1, n);
      sb.push_back(12'h777);
      check("mr_recapture_latency", n, S + 1);
      check("mr_fill_one", fill_level, 1);
      tx_req = 1'b0;
      wait_ack(1'b0, n);
      sample_ready = 1'b1; tick(); sample_ready = 1'b0;
      tick();
      check("mr_pop_dac", dac_code, 12'h777);
      check("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
